// File: rtl/stack_pop_sequencer_pkg.sv
// Shared definitions for the stack pop sequencer and the PC/flags accumulator decoder.
// Phase and mode codes are common to both sides of the interface.
package stack_pop_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_PA    = 3'd2;
    localparam state_t ST_PB    = 3'd3;
    localparam state_t ST_PC    = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    localparam logic [1:0] PH_NONE = 2'b00;
    localparam logic [1:0] PH_01   = 2'b01;
    localparam logic [1:0] PH_10   = 2'b10;
    localparam logic [1:0] PH_11   = 2'b11;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_RET  = 2'b10;
    localparam logic [1:0] MODE_RTI  = 2'b11;

    // Phase names the word on the read bus this cycle, i.e. the read issued one cycle earlier.
    function automatic logic [1:0] phase_code(input state_t st, input logic is_rti);
        logic [1:0] ph;
        ph = PH_NONE;
        case (st)
            ST_PA:   ph = is_rti ? PH_11 : PH_10;
            ST_PB:   ph = is_rti ? PH_10 : PH_01;
            ST_PC:   ph = PH_01;
            default: ph = PH_NONE;
        endcase
        return ph;
    endfunction

    function automatic logic reads_in_state(input state_t st, input logic is_rti);
        logic rd;
        rd = 1'b0;
        case (st)
            ST_ISSUE, ST_PA: rd = 1'b1;
            ST_PB:           rd = is_rti;
            default:         rd = 1'b0;
        endcase
        return rd;
    endfunction

endpackage

// File: rtl/stack_pop_if.sv
// Request / stack-read / accumulator-control bundle of the stack pop sequencer.
// The sequencer uses the master modport; the requester and stack memory side uses slave.
interface stack_pop_if #(
    parameter int ADDR_W = 32
);
    logic              ret_req;
    logic              rti_req;
    logic              push_req;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W-1:0] sp;
    logic [1:0]        state_out;
    logic              stack_pc;
    logic              stack_flags;
    logic              stall;
    logic              pc_load;

    modport master (
        input  ret_req, rti_req, push_req,
        output mem_rd, mem_raddr, sp, state_out, stack_pc, stack_flags, stall, pc_load
    );

    modport slave (
        output ret_req, rti_req, push_req,
        input  mem_rd, mem_raddr, sp, state_out, stack_pc, stack_flags, stall, pc_load
    );
endinterface

// File: rtl/stack_pop_sequencer.sv
// Owns the stack pointer and sequences RET/RTI stack pops into the PC/flags accumulator.
//
//  state | meaning
//  IDLE  | sample requests, apply single-word pushes
//  ISSUE | first stack read issued, nothing on the bus yet
//  PA    | PC[15:0] on the bus
//  PB    | PC[31:16] (RTI) or PC[31:16] last word (RET)
//  PC    | flags word on the bus (RTI only)
//  DONE  | pc_load pulse, mode cleared on exit
module stack_pop_sequencer
    import stack_pop_sequencer_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] SP_INIT = 32'h000F_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    stack_pop_if.master bus
);
    localparam logic [ADDR_W-1:0] SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] sp_inc;
    logic [1:0]        mode_q;
    logic              is_rti;
    logic              rd_now;

    assign is_rti = (mode_q == MODE_RTI);
    assign sp_inc = sp_q + SP_ONE;
    assign rd_now = reads_in_state(state, is_rti);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sp_q   <= SP_INIT;
            mode_q <= MODE_NONE;
        end else begin
            // Every read post-increments SP; wraps silently at 2^ADDR_W.
            if (rd_now) begin
                sp_q <= sp_inc;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.rti_req) begin
                        mode_q <= MODE_RTI;
                        state  <= ST_ISSUE;
                    end else if (bus.ret_req) begin
                        mode_q <= MODE_RET;
                        state  <= ST_ISSUE;
                    end else if (bus.push_req) begin
                        sp_q <= sp_q - SP_ONE;
                    end
                end
                ST_ISSUE: state <= ST_PA;
                ST_PA:    state <= ST_PB;
                ST_PB:    state <= is_rti ? ST_PC : ST_DONE;
                ST_PC:    state <= ST_DONE;
                ST_DONE: begin
                    state  <= ST_IDLE;
                    mode_q <= MODE_NONE;
                end
                default: begin
                    state  <= ST_IDLE;
                    mode_q <= MODE_NONE;
                end
            endcase
        end
    end

    assign bus.mem_rd      = rd_now;
    assign bus.mem_raddr   = rd_now ? sp_inc : '0;
    assign bus.sp          = sp_q;
    assign bus.state_out   = phase_code(state, is_rti);
    assign bus.stack_pc    = mode_q[1];
    assign bus.stack_flags = mode_q[0];
    assign bus.stall       = (state != ST_IDLE);
    assign bus.pc_load     = (state == ST_DONE);

endmodule

// File: tb/tb_stack_pop_sequencer.sv
// Self-checking bench: directed scenarios, a vector table and randomized ops against a
// transaction-level model of SP, read addresses, phase labels and the rebuilt PC/flags.
module tb_stack_pop_sequencer;
    import stack_pop_sequencer_pkg::*;

    localparam logic [31:0] SP_RST = 32'h000F_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_pop_if #(.ADDR_W(32)) bus ();
    stack_pop_if #(.ADDR_W(32)) bw ();

    stack_pop_sequencer #(.ADDR_W(32), .SP_INIT(SP_RST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    stack_pop_sequencer #(.ADDR_W(32), .SP_INIT(32'hFFFF_FFFF)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bw)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] model_sp;
    logic [15:0] mem_ovr [logic [31:0]];
    logic [15:0] rdata;
    logic [31:0] acc_pc;
    logic [2:0]  acc_flags;

    logic [1:0] ph_ret [4] = '{2'b00, 2'b10, 2'b01, 2'b00};
    logic [1:0] ph_rti [5] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b00};

    typedef struct {
        logic       rti;
        logic       ret;
        logic       push;
        int         len;
        logic [1:0] mode;
        int         delta;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a[15:0] ^ a[31:16] ^ 16'h3C5A;
    endfunction

    // Synchronous stack memory, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd) rdata <= mem_word(bus.mem_raddr);
    end

    // Accumulator: mode + phase select which slot the bus word lands in.
    always @(posedge clk) begin
        case ({bus.stack_pc, bus.stack_flags, bus.state_out})
            4'b1010: acc_pc[15:0]  <= rdata;
            4'b1001: acc_pc[31:16] <= rdata;
            4'b1111: acc_pc[15:0]  <= rdata;
            4'b1110: acc_pc[31:16] <= rdata;
            4'b1101: acc_flags     <= rdata[2:0];
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void model_expect(input logic rti, input logic ret, input logic push,
                                         output int len, output logic [1:0] mode, output int delta);
        if (rti) begin
            len = 5; mode = 2'b11; delta = 3;
        end else if (ret) begin
            len = 4; mode = 2'b10; delta = 2;
        end else begin
            len = 0; mode = 2'b00; delta = push ? -1 : 0;
        end
    endfunction

    // One request cycle followed by the whole expected sequence; inject_at pulses ret_req mid-pop.
    task automatic run_op(input string name, input logic rti, input logic ret, input logic push,
                          input int len, input logic [1:0] mode, input int delta, input int inject_at);
        logic [31:0] sp0;
        logic [31:0] exp_pc;
        logic [1:0]  ph;
        @(negedge clk);
        sp0 = model_sp;
        exp_pc = {mem_word(sp0 + 32'd2), mem_word(sp0 + 32'd1)};
        bus.rti_req  = rti;
        bus.ret_req  = ret;
        bus.push_req = push;
        @(posedge clk); #1;
        bus.rti_req  = 1'b0;
        bus.ret_req  = 1'b0;
        bus.push_req = 1'b0;
        for (int i = 0; i < len; i++) begin
            ph = (len == 5) ? ph_rti[i] : ph_ret[i];
            check($sformatf("%s c%0d stall", name, i), 32'(bus.stall), 32'd1);
            check($sformatf("%s c%0d state_out", name, i), 32'(bus.state_out), 32'(ph));
            check($sformatf("%s c%0d mode", name, i), 32'({bus.stack_pc, bus.stack_flags}), 32'(mode));
            check($sformatf("%s c%0d mem_rd", name, i), 32'(bus.mem_rd), 32'(i < len - 2));
            if (i < len - 2)
                check($sformatf("%s c%0d raddr", name, i), bus.mem_raddr, sp0 + 32'd1 + 32'(i));
            check($sformatf("%s c%0d pc_load", name, i), 32'(bus.pc_load), 32'(i == len - 1));
            if (i == len - 1) begin
                check($sformatf("%s outPC", name), acc_pc, exp_pc);
                if (len == 5)
                    check($sformatf("%s flags", name), 32'(acc_flags),
                          32'(mem_word(sp0 + 32'd3) & 16'h0007));
            end
            if (i == inject_at) bus.ret_req = 1'b1;
            @(posedge clk); #1;
            bus.ret_req = 1'b0;
        end
        model_sp = sp0 + 32'(delta);
        check($sformatf("%s end stall", name), 32'(bus.stall), 32'd0);
        check($sformatf("%s end pc_load", name), 32'(bus.pc_load), 32'd0);
        check($sformatf("%s end sp", name), bus.sp, model_sp);
    endtask

    initial begin
        int         len;
        int         delta;
        logic [1:0] mode;
        logic       rti, ret, push;
        logic       seen;

        bus.ret_req = 1'b0; bus.rti_req = 1'b0; bus.push_req = 1'b0;
        bw.ret_req  = 1'b0; bw.rti_req  = 1'b0; bw.push_req  = 1'b0;
        model_sp = SP_RST;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 2'b00,  0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 0, 2'b00, -1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4, 2'b10,  2};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 5, 2'b11,  3};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 5, 2'b11,  3};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 4, 2'b10,  2};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 5, 2'b11,  3};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 5, 2'b11,  3};

        #12;
        check("rst sp", bus.sp, SP_RST);
        check("rst stall", 32'(bus.stall), 32'd0);
        check("rst pc_load", 32'(bus.pc_load), 32'd0);
        check("rst mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst state_out", 32'(bus.state_out), 32'd0);
        check("rst mode", 32'({bus.stack_pc, bus.stack_flags}), 32'd0);
        check("rst wrap sp", bw.sp, 32'hFFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;

        // RET from 000F_FFFD.
        run_op("push1", 1'b0, 1'b0, 1'b1, 0, 2'b00, -1, -1);
        run_op("push2", 1'b0, 1'b0, 1'b1, 0, 2'b00, -1, -1);
        check("ret start sp", bus.sp, 32'h000F_FFFD);
        mem_ovr[32'h000F_FFFE] = 16'h1234;
        mem_ovr[32'h000F_FFFF] = 16'h0000;
        run_op("ret", 1'b0, 1'b1, 1'b0, 4, 2'b10, 2, -1);
        check("ret outPC const", acc_pc, 32'h0000_1234);
        check("ret sp const", bus.sp, 32'h000F_FFFF);

        // Three pushes, then RTI.
        run_op("p3a", 1'b0, 1'b0, 1'b1, 0, 2'b00, -1, -1);
        run_op("p3b", 1'b0, 1'b0, 1'b1, 0, 2'b00, -1, -1);
        run_op("p3c", 1'b0, 1'b0, 1'b1, 0, 2'b00, -1, -1);
        check("push x3 sp", bus.sp, 32'h000F_FFFC);
        mem_ovr[32'h000F_FFFD] = 16'hBEEF;
        mem_ovr[32'h000F_FFFE] = 16'h0001;
        mem_ovr[32'h000F_FFFF] = 16'h0005;
        run_op("rti", 1'b1, 1'b0, 1'b0, 5, 2'b11, 3, -1);
        check("rti outPC const", acc_pc, 32'h0001_BEEF);
        check("rti flags const", 32'(acc_flags), 32'h5);
        check("rti sp const", bus.sp, 32'h000F_FFFF);

        // ret_req arriving during a stall must not start a second sequence.
        run_op("rti+ret_in_stall", 1'b1, 1'b0, 1'b0, 5, 2'b11, 3, 1);
        run_op("idle after", 1'b0, 1'b0, 1'b0, 0, 2'b00, 0, -1);
        run_op("idle after2", 1'b0, 1'b0, 1'b0, 0, 2'b00, 0, -1);

        for (int v = 0; v < 8; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].rti, vecs[v].ret, vecs[v].push,
                   vecs[v].len, vecs[v].mode, vecs[v].delta, -1);
        end

        for (int r = 0; r < 60; r++) begin
            rti  = ($urandom_range(0, 3) == 0);
            ret  = ($urandom_range(0, 2) == 0);
            push = ($urandom_range(0, 1) == 1);
            for (int k = 1; k <= 3; k++) mem_ovr[model_sp + 32'(k)] = 16'($urandom);
            model_expect(rti, ret, push, len, mode, delta);
            run_op($sformatf("rnd%0d", r), rti, ret, push, len, mode, delta, -1);
        end

        // Reset asserted while an RTI is in PB.
        @(negedge clk);
        bus.rti_req = 1'b1;
        @(posedge clk); #1;
        bus.rti_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst in PB", 32'(bus.state_out), 32'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        check("midrst stall", 32'(bus.stall), 32'd0);
        check("midrst sp", bus.sp, SP_RST);
        check("midrst state_out", 32'(bus.state_out), 32'd0);
        check("midrst mode", 32'({bus.stack_pc, bus.stack_flags}), 32'd0);
        seen = bus.pc_load;
        @(negedge clk);
        seen = seen | bus.pc_load;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            seen = seen | bus.pc_load | bus.stall;
        end
        check("midrst no pc_load/stall", 32'(seen), 32'd0);
        model_sp = SP_RST;
        run_op("post rst idle", 1'b0, 1'b0, 1'b0, 0, 2'b00, 0, -1);

        // SP wrap on the instance that comes out of reset at FFFF_FFFF.
        @(negedge clk);
        bw.ret_req = 1'b1;
        @(posedge clk); #1;
        bw.ret_req = 1'b0;
        check("wrap rd0", 32'(bw.mem_rd), 32'd1);
        check("wrap raddr0", bw.mem_raddr, 32'h0000_0000);
        @(posedge clk); #1;
        check("wrap raddr1", bw.mem_raddr, 32'h0000_0001);
        check("wrap ph PA", 32'(bw.state_out), 32'(2'b10));
        @(posedge clk); #1;
        check("wrap rd PB", 32'(bw.mem_rd), 32'd0);
        check("wrap ph PB", 32'(bw.state_out), 32'(2'b01));
        @(posedge clk); #1;
        check("wrap pc_load", 32'(bw.pc_load), 32'd1);
        @(posedge clk); #1;
        check("wrap sp", bw.sp, 32'h0000_0001);
        check("wrap stall", 32'(bw.stall), 32'd0);
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            bw.push_req = 1'b1;
            @(posedge clk); #1;
            bw.push_req = 1'b0;
        end
        check("wrap push under", bw.sp, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
